ps2_kbd_ctrl: RTL

Sequencer sitting between the CPU-facing register block and one ps2_port instance. It issues 1- or 2-byte host commands to the keyboard, e.g. 0xED+LED mask or 0xF4. It waits for the device response byte (0xFA ACK / 0xFE RESEND), retries on resend, port error or timeout, and reports done/error. All other received bytes are buffered in a scan-code FIFO for the CPU.

---
 rtl/ps2_kbd_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: host-command sequencer in front of one ps2_port.
// Sends a 1- or 2-byte command to the keyboard, waits for the port line-ACK and
// the device response (0xFA ACK / 0xFE RESEND), retries on resend, line error or
// timeout, and reports done/error. Every other received byte goes into a
// first-word-fall-through scan-code FIFO for the CPU.
//
// Ports:
//   clk6x, resetn            48 MHz clock, async active-low reset
//   ck1us                    1 us tick (one clk6x cycle wide)
//   hcmd_i/harg_i/hcmd_two_i command byte, argument byte, argument present
//   hcmd_v_i                 start pulse (ignored while busy)
//   hcmd_busy_o/done_o/err_o status: busy level, done pulse, error pulse
//   sc_data_o/sc_empty_o     FIFO head and empty flag
//   sc_rd_i                  pop FIFO head
//   sc_ovf_o/sc_ovf_clr_i    sticky overflow flag and its clear
//   cmd_tx_o/cmd_tx_v_o      byte and TX request towards ps2_port
//   cmd_tx_deq_i             port took the byte
//   port_busy_i              port transmit in progress
//   tx_acked_i/tx_errd_i     port line-ACK / line error
//   code_rx_i/code_rx_v_i    received byte and its one-cycle valid
module ps2_kbd_ctrl #(
  parameter int unsigned FIFO_AW         = 4,
  parameter int unsigned RESP_TIMEOUT_US = 20000,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic       ck1us,
  input  logic [7:0] hcmd_i,
  input  logic [7:0] harg_i,
  input  logic       hcmd_two_i,
  input  logic       hcmd_v_i,
  output logic       hcmd_busy_o,
  output logic       hcmd_done_o,
  output logic       hcmd_err_o,
  output logic [7:0] sc_data_o,
  output logic       sc_empty_o,
  input  logic       sc_rd_i,
  output logic       sc_ovf_o,
  input  logic       sc_ovf_clr_i,
  output logic [7:0] cmd_tx_o,
  output logic       cmd_tx_v_o,
  input  logic       cmd_tx_deq_i,
  input  logic       port_busy_i,
  input  logic       tx_acked_i,
  input  logic       tx_errd_i,
  input  logic [7:0] code_rx_i,
  input  logic       code_rx_v_i
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PW    = FIFO_AW + 1;
  localparam int unsigned TW    = $clog2(RESP_TIMEOUT_US + 1);
  localparam int unsigned RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [7:0]  CODE_ACK    = 8'hFA;
  localparam logic [7:0]  CODE_RESEND = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND, ST_TXWAIT, ST_RESP, ST_DONE, ST_ERR
  } state_t;

  state_t          state, state_n;
  logic            sel, sel_n;
  logic [RW-1:0]   retry, retry_n;
  logic            retry_c;
  logic [7:0]      cmd_q, arg_q;
  logic            two_q;
  logic [TW-1:0]   timer;
  logic            busy_q, done_q, err_q, tx_v_q;
  logic [7:0]      tx_byte_q;

  logic            accept_c, timeout_c, rx_ack_c, rx_resend_c;

  assign accept_c    = (state == ST_IDLE) && hcmd_v_i;
  assign timeout_c   = (timer == TW'(RESP_TIMEOUT_US));
  assign rx_ack_c    = code_rx_v_i && (code_rx_i == CODE_ACK);
  assign rx_resend_c = code_rx_v_i && (code_rx_i == CODE_RESEND);

  // Next-state, byte select and retry bookkeeping
  always_comb begin
    state_n = state;
    sel_n   = sel;
    retry_n = retry;
    retry_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hcmd_v_i) begin
          state_n = ST_SEND;
          sel_n   = 1'b0;
          retry_n = '0;
        end
      end
      ST_SEND: begin
        if (cmd_tx_deq_i) state_n = ST_TXWAIT;
      end
      ST_TXWAIT: begin
        if (tx_acked_i)                  state_n = ST_RESP;
        else if (tx_errd_i || timeout_c) retry_c = 1'b1;
      end
      ST_RESP: begin
        if (rx_ack_c) begin
          if (!sel && two_q) begin
            sel_n   = 1'b1;
            retry_n = '0;
            state_n = ST_SEND;
          end else begin
            state_n = ST_DONE;
          end
        end else if (rx_resend_c || timeout_c) begin
          retry_c = 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      ST_ERR:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    // Same byte is re-sent until the retry budget is spent
    if (retry_c) begin
      if (retry < RW'(MAX_RETRY)) begin
        retry_n = retry + RW'(1);
        state_n = ST_SEND;
      end else begin
        state_n = ST_ERR;
      end
    end
  end

  // State, command latch and registered status/TX outputs
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      sel       <= 1'b0;
      retry     <= '0;
      cmd_q     <= 8'h00;
      arg_q     <= 8'h00;
      two_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tx_v_q    <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state  <= state_n;
      sel    <= sel_n;
      retry  <= retry_n;
      if (accept_c) begin
        cmd_q <= hcmd_i;
        arg_q <= harg_i;
        two_q <= hcmd_two_i;
      end
      busy_q    <= (state_n != ST_IDLE);
      done_q    <= (state_n == ST_DONE);
      err_q     <= (state_n == ST_ERR);
      tx_v_q    <= (state_n == ST_SEND) && !port_busy_i;
      tx_byte_q <= accept_c ? hcmd_i : (sel_n ? arg_q : cmd_q);
    end
  end

  // Phase timer: restarts on every state change, counts 1 us ticks while waiting
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      timer <= '0;
    end else if (state_n != state) begin
      timer <= '0;
    end else if ((state == ST_TXWAIT || state == ST_RESP) && ck1us && !timeout_c) begin
      timer <= timer + TW'(1);
    end
  end

  assign hcmd_busy_o = busy_q;
  assign hcmd_done_o = done_q;
  assign hcmd_err_o  = err_q;
  assign cmd_tx_v_o  = tx_v_q;
  assign cmd_tx_o    = tx_byte_q;

  // Scan-code FIFO; ACK/RESEND are only swallowed while a response is awaited
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty_c, full_c, push_req_c, push_c, pop_c, ovf_set_c;
  logic          ovf_q;

  assign empty_c    = (wr_ptr == rd_ptr);
  assign full_c     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign push_req_c = code_rx_v_i && !((state == ST_RESP) && (rx_ack_c || rx_resend_c));
  assign pop_c      = sc_rd_i && !empty_c;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push_c     = push_req_c && (!full_c || pop_c);
  assign ovf_set_c  = push_req_c && full_c && !pop_c;

  always_ff @(posedge clk6x) begin
    if (push_c) mem[wr_ptr[FIFO_AW-1:0]] <= code_rx_i;
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_c)         wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)          rd_ptr <= rd_ptr + PW'(1);
      if (ovf_set_c)      ovf_q  <= 1'b1;
      else if (sc_ovf_clr_i) ovf_q <= 1'b0;
    end
  end

  assign sc_empty_o = empty_c;
  assign sc_data_o  = empty_c ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];
  assign sc_ovf_o   = ovf_q;

endmodule
